layer_sequencer: RTL and testbench

- Controller that time-multiplexes a single LAYER_SIZE-neuron layer datapath across NUM_LAYERS network layers.
- Accepts one input vector over a valid/ready stream and holds activations in a ping-pong buffer.
- Issues weight-memory reads and sequences the neuron clear, accumulate, capture and drain strobes once per layer.
- Feeds each layer's serial activated outputs back as the next layer's input, then streams the final vector out.

---
 rtl/layer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer: reuses one LAYER_SIZE-neuron datapath across NUM_LAYERS layers,
// ping-ponging activations between two buffers and streaming the final vector out.
module layer_sequencer #(
  parameter int unsigned LAYER_SIZE = 3,
  parameter int unsigned BIT_SIZE   = 8,
  parameter int unsigned NUM_LAYERS = 2,
  localparam int unsigned AW = (LAYER_SIZE * NUM_LAYERS > 1) ? $clog2(LAYER_SIZE * NUM_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic [AW-1:0]       w_addr,
  output logic                w_rd_en,
  output logic                neuron_rst,
  output logic                acc_en,
  output logic [BIT_SIZE-1:0] x,
  output logic                capture,
  output logic                shift_en,
  input  logic [BIT_SIZE-1:0] y
);
  localparam int unsigned KW = $clog2(LAYER_SIZE);
  localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LAYER_SIZE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {LOAD, CLEAR, ACCUM, CAPTURE, DRAIN, OUTPUT} state_t;

  state_t              state, state_nxt;
  logic [KW-1:0]       k, k_nxt, j, j_nxt;
  logic [LW-1:0]       layer, layer_nxt;
  logic                sel, sel_nxt;
  logic                load_we, drain_we;
  logic [AW-1:0]       base;
  logic [BIT_SIZE-1:0] buf_a [LAYER_SIZE];
  logic [BIT_SIZE-1:0] buf_b [LAYER_SIZE];

  // sel=0: buf_a holds the current layer input, buf_b collects its output
  assign base = AW'(layer) * AW'(LAYER_SIZE);
  assign busy = (state != LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      k     <= '0;
      j     <= '0;
      layer <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      j     <= j_nxt;
      layer <= layer_nxt;
      sel   <= sel_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) buf_a[k] <= in_data;
    if (drain_we) begin
      if (sel) buf_a[k] <= y;
      else     buf_b[k] <= y;
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    j_nxt      = j;
    layer_nxt  = layer;
    sel_nxt    = sel;
    load_we    = 1'b0;
    drain_we   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    w_addr     = '0;
    w_rd_en    = 1'b0;
    neuron_rst = 1'b0;
    acc_en     = 1'b0;
    x          = '0;
    capture    = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          if (k == K_LAST) begin
            k_nxt     = '0;
            state_nxt = CLEAR;
          end else begin
            k_nxt = k + KW'(1);
          end
        end
      end
      CLEAR: begin
        neuron_rst = 1'b1;
        w_rd_en    = 1'b1;
        w_addr     = base;
        j_nxt      = '0;
        state_nxt  = ACCUM;
      end
      ACCUM: begin
        acc_en = 1'b1;
        x      = sel ? buf_b[j] : buf_a[j];
        // prefetch the next row so it lands with the next acc_en
        if (j == K_LAST) begin
          state_nxt = CAPTURE;
        end else begin
          w_rd_en = 1'b1;
          w_addr  = base + AW'(j) + AW'(1);
          j_nxt   = j + KW'(1);
        end
      end
      CAPTURE: begin
        capture   = 1'b1;
        k_nxt     = '0;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        shift_en = 1'b1;
        drain_we = 1'b1;
        if (k == K_LAST) begin
          k_nxt   = '0;
          sel_nxt = ~sel;
          if (layer == L_LAST) begin
            state_nxt = OUTPUT;
          end else begin
            layer_nxt = layer + LW'(1);
            state_nxt = CLEAR;
          end
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_data  = sel ? buf_b[k] : buf_a[k];
        out_last  = (k == K_LAST);
        if (out_ready) begin
          if (k == K_LAST) begin
            k_nxt     = '0;
            layer_nxt = '0;
            sel_nxt   = 1'b0;
            state_nxt = LOAD;
          end else begin
            k_nxt = k + KW'(1);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: identity-weight datapath model, input/output
// scoreboard, strobe/address trace and latency checks.
module tb_layer_sequencer;
  localparam int unsigned N  = 3;
  localparam int unsigned BW = 8;
  localparam int unsigned L  = 2;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [AW-1:0] w_addr;
  logic          w_rd_en, neuron_rst, acc_en, capture, shift_en;
  logic [BW-1:0] x, y;

  layer_sequencer #(.LAYER_SIZE(N), .BIT_SIZE(BW), .NUM_LAYERS(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .w_addr(w_addr), .w_rd_en(w_rd_en), .neuron_rst(neuron_rst),
    .acc_en(acc_en), .x(x), .capture(capture), .shift_en(shift_en), .y(y)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: weight row for address a is the identity row (a mod N)
  logic [BW-1:0] w_row [N];
  logic [BW-1:0] acc   [N];
  logic [BW-1:0] shreg [N];
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (w_rd_en) w_row[i] <= (i == int'(w_addr) % int'(N)) ? BW'(1) : '0;
      if (neuron_rst)  acc[i] <= '0;
      else if (acc_en) acc[i] <= acc[i] + BW'(x * w_row[i]);
    end
    if (capture) begin
      for (int i = 0; i < int'(N); i++) shreg[i] <= acc[i];
    end else if (shift_en) begin
      for (int i = 0; i < int'(N) - 1; i++) shreg[i] <= shreg[i+1];
      shreg[N-1] <= '0;
    end
  end
  assign y = shreg[0];

  int n_cmp = 0;
  int n_err = 0;

  logic [BW-1:0] sb[$];
  int unsigned   acc_cyc[$];
  logic [BW-1:0] obs_d[$];
  bit            obs_last[$];
  int unsigned   obs_hs[$];
  logic [AW-1:0] obs_addr[$];
  logic [BW-1:0] obs_x[$];
  logic [BW-1:0] stall_d[$];
  bit            stall_last[$];
  int unsigned   first_valid_cyc;

  // Drives words first..first+count-1; valid follows pat bits for the first pat_len cycles.
  task automatic drive_in(input int unsigned first, input int unsigned count,
                          input int unsigned pat_len, input logic [31:0] pat);
    int unsigned sent = 0, p = 0, guard = 0;
    while (sent < count && guard < 500) begin
      @(negedge clk);
      in_valid = (p < pat_len) ? pat[p] : 1'b1;
      in_data  = in_valid ? BW'(first + sent) : '0;
      p++;
      guard++;
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(BW'(first + sent));
        acc_cyc.push_back(cyc + 1);
        sent++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic collect(input int unsigned n_words, input int unsigned stall_at,
                         input int unsigned stall_len);
    int unsigned got = 0, stalls = 0, budget = 0;
    bit seen = 1'b0;
    obs_d.delete(); obs_last.delete(); obs_hs.delete();
    obs_addr.delete(); obs_x.delete(); stall_d.delete(); stall_last.delete();
    first_valid_cyc = 0;
    while (got < n_words && budget < 400) begin
      @(negedge clk);
      budget++;
      if (out_valid && got == stall_at && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
        stall_d.push_back(out_data);
        stall_last.push_back(out_last);
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (w_rd_en) obs_addr.push_back(w_addr);
      if (acc_en) obs_x.push_back(x);
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data);
        obs_last.push_back(out_last);
        obs_hs.push_back(cyc + 1);
        got++;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++;
    if ({out_valid, out_last, w_rd_en, neuron_rst, acc_en, capture, shift_en} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_strobes got=%b exp=0000000",
               {out_valid, out_last, w_rd_en, neuron_rst, acc_en, capture, shift_en});
    end
    n_cmp++; if (w_addr !== '0) begin n_err++; $display("FAIL reset_w_addr got=%0d exp=0", w_addr); end
    n_cmp++; if (x !== '0) begin n_err++; $display("FAIL reset_x got=%0d exp=0", x); end
  endtask

  task automatic test_single();
    logic [BW-1:0] exp;
    sb.delete(); acc_cyc.delete();
    drive_in(1, 3, 0, 32'h0);
    collect(3, 99, 0);
    n_cmp++; if (obs_addr.size() != 6) begin n_err++; $display("FAIL single_addr_count got=%0d exp=6", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 6; i++) begin
      n_cmp++;
      if (obs_addr[i] !== AW'(i)) begin n_err++; $display("FAIL single_w_addr[%0d] got=%0d exp=%0d", i, obs_addr[i], i); end
    end
    n_cmp++; if (obs_x.size() != 6) begin n_err++; $display("FAIL single_x_count got=%0d exp=6", obs_x.size()); end
    for (int i = 0; i < obs_x.size() && i < 6; i++) begin
      n_cmp++;
      if (obs_x[i] !== BW'(i % 3 + 1)) begin n_err++; $display("FAIL single_x[%0d] got=%0d exp=%0d", i, obs_x[i], i % 3 + 1); end
    end
    n_cmp++;
    if (acc_cyc.size() != 3 || first_valid_cyc != acc_cyc[2] + 16) begin
      n_err++;
      $display("FAIL single_latency got=%0d exp=16", (acc_cyc.size() == 3) ? int'(first_valid_cyc) - int'(acc_cyc[2]) : -1);
    end
    n_cmp++; if (obs_d.size() != 3) begin n_err++; $display("FAIL single_out_count got=%0d exp=3", obs_d.size()); end
    for (int i = 0; i < obs_d.size(); i++) begin
      if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL single_sb_empty got=%0d exp=none", obs_d[i]); end
      else begin
        exp = sb.pop_front();
        n_cmp++; if (obs_d[i] !== exp) begin n_err++; $display("FAIL single_out[%0d] got=%0d exp=%0d", i, obs_d[i], exp); end
        n_cmp++; if (obs_last[i] !== (i == 2)) begin n_err++; $display("FAIL single_last[%0d] got=%b exp=%b", i, obs_last[i], i == 2); end
      end
    end
  endtask

  task automatic test_bubbles();
    logic [BW-1:0] exp;
    sb.delete(); acc_cyc.delete();
    drive_in(4, 3, 6, 32'b101001);
    collect(3, 99, 0);
    n_cmp++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 2) begin
      n_err++;
      $display("FAIL bubbles_accept_spacing got=%0d accepts exp=3 at gaps 3,2", acc_cyc.size());
    end
    n_cmp++; if (obs_d.size() != 3) begin n_err++; $display("FAIL bubbles_out_count got=%0d exp=3", obs_d.size()); end
    for (int i = 0; i < obs_d.size(); i++) begin
      if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL bubbles_sb_empty got=%0d exp=none", obs_d[i]); end
      else begin
        exp = sb.pop_front();
        n_cmp++; if (obs_d[i] !== exp) begin n_err++; $display("FAIL bubbles_out[%0d] got=%0d exp=%0d", i, obs_d[i], exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] exp;
    sb.delete(); acc_cyc.delete();
    drive_in(1, 3, 0, 32'h0);
    collect(3, 1, 5);
    n_cmp++; if (stall_d.size() != 5) begin n_err++; $display("FAIL bp_stall_count got=%0d exp=5", stall_d.size()); end
    for (int i = 0; i < stall_d.size(); i++) begin
      n_cmp++; if (stall_d[i] !== BW'(2)) begin n_err++; $display("FAIL bp_hold_data[%0d] got=%0d exp=2", i, stall_d[i]); end
      n_cmp++; if (stall_last[i] !== 1'b0) begin n_err++; $display("FAIL bp_hold_last[%0d] got=%b exp=0", i, stall_last[i]); end
    end
    n_cmp++; if (obs_d.size() != 3) begin n_err++; $display("FAIL bp_out_count got=%0d exp=3", obs_d.size()); end
    for (int i = 0; i < obs_d.size(); i++) begin
      if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL bp_sb_empty got=%0d exp=none", obs_d[i]); end
      else begin
        exp = sb.pop_front();
        n_cmp++; if (obs_d[i] !== exp) begin n_err++; $display("FAIL bp_out[%0d] got=%0d exp=%0d", i, obs_d[i], exp); end
        n_cmp++; if (obs_last[i] !== (i == 2)) begin n_err++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, obs_last[i], i == 2); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [BW-1:0] exp;
    bit found = 1'b0;
    sb.delete(); acc_cyc.delete();
    drive_in(1, 3, 0, 32'h0);
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      #1;
      // layer 1, ACCUM j=1 prefetches row 3+2
      if (acc_en && w_rd_en && w_addr == AW'(5)) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL midrst_reach_accum got=timeout exp=acc_en with w_addr=5"); end
    else begin
      n_cmp++; if (x !== BW'(2)) begin n_err++; $display("FAIL midrst_x got=%0d exp=2", x); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_state got=ready%b busy%b exp=ready1 busy0", in_ready, busy); end
      n_cmp++;
      if ({out_valid, w_rd_en, neuron_rst, acc_en, capture, shift_en} !== 6'b0 || w_addr !== '0) begin
        n_err++;
        $display("FAIL midrst_strobes got=%b addr=%0d exp=000000 addr=0",
                 {out_valid, w_rd_en, neuron_rst, acc_en, capture, shift_en}, w_addr);
      end
    end
    sb.delete(); acc_cyc.delete();
    drive_in(7, 3, 0, 32'h0);
    collect(3, 99, 0);
    n_cmp++; if (obs_d.size() != 3) begin n_err++; $display("FAIL midrst_out_count got=%0d exp=3", obs_d.size()); end
    for (int i = 0; i < obs_d.size(); i++) begin
      if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL midrst_sb_empty got=%0d exp=none", obs_d[i]); end
      else begin
        exp = sb.pop_front();
        n_cmp++; if (obs_d[i] !== exp) begin n_err++; $display("FAIL midrst_out[%0d] got=%0d exp=%0d", i, obs_d[i], exp); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp;
    sb.delete(); acc_cyc.delete();
    fork
      drive_in(1, 6, 0, 32'h0);
      collect(6, 99, 0);
    join
    n_cmp++;
    if (acc_cyc.size() != 6 || obs_hs.size() < 3 || acc_cyc[3] != obs_hs[2] + 1) begin
      n_err++;
      $display("FAIL b2b_hold_off got=accept4@%0d exp=%0d",
               (acc_cyc.size() > 3) ? acc_cyc[3] : 0, (obs_hs.size() > 2) ? obs_hs[2] + 1 : 0);
    end
    n_cmp++; if (obs_d.size() != 6) begin n_err++; $display("FAIL b2b_out_count got=%0d exp=6", obs_d.size()); end
    for (int i = 0; i < obs_d.size(); i++) begin
      if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL b2b_sb_empty got=%0d exp=none", obs_d[i]); end
      else begin
        exp = sb.pop_front();
        n_cmp++; if (obs_d[i] !== exp) begin n_err++; $display("FAIL b2b_out[%0d] got=%0d exp=%0d", i, obs_d[i], exp); end
        n_cmp++; if (obs_last[i] !== (i % 3 == 2)) begin n_err++; $display("FAIL b2b_last[%0d] got=%b exp=%b", i, obs_last[i], i % 3 == 2); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_bubbles();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
